// File: rtl/darkboot_loader.sv
// Boot loader that streams a length-prefixed byte image into memory
// while holding the core in reset until the image is complete.
module darkboot_loader #(
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int          MAXW = 512
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VLD,
  output logic        RX_RDY,
  output logic        WR,
  output logic [31:0] ADDR,
  output logic [31:0] DATA,
  output logic [3:0]  BE,
  input  logic        ACK,
  input  logic        START,
  output logic        HOLD,
  output logic        DONE,
  output logic        ERR
);

  localparam int          IW    = $clog2(MAXW + 1);
  localparam logic [31:0] LIMIT = 32'(MAXW);

  typedef enum logic [2:0] {
    S_HDR, S_DATA, S_WRITE, S_FIN, S_ERR
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      bidx;
  logic [23:0]     acc;
  logic [IW-1:0]   cnt, n, cnt_inc;
  logic [31:0]     word;
  logic            take, last, restart;

  // RX_RDY is gated by XRES so it drops at once, not at the next edge.
  assign RX_RDY  = !XRES && (state == S_HDR || state == S_DATA);
  assign take    = RX_VLD && RX_RDY;
  assign last    = take && (bidx == 2'd3);
  assign word    = {RX_DATA, acc};
  assign cnt_inc = cnt + 1'b1;
  assign restart = START && (state == S_FIN || state == S_ERR);

  assign WR   = (state == S_WRITE);
  assign BE   = WR ? 4'hF : 4'h0;
  assign ADDR = BASE + {{(30-IW){1'b0}}, cnt, 2'b00};
  assign HOLD = (state != S_FIN);
  assign DONE = (state == S_FIN);
  assign ERR  = (state == S_ERR);

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) state <= S_HDR;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_HDR: begin
        if (last) begin
          if (word == 32'd0)     state_nx = S_FIN;
          else if (word > LIMIT) state_nx = S_ERR;
          else                   state_nx = S_DATA;
        end
      end
      S_DATA:  if (last) state_nx = S_WRITE;
      S_WRITE: if (ACK)  state_nx = (cnt_inc == n) ? S_FIN : S_DATA;
      S_FIN,
      S_ERR:   if (START) state_nx = S_HDR;
      default: state_nx = S_HDR;
    endcase
  end

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      bidx <= 2'd0;
      acc  <= 24'd0;
      cnt  <= '0;
      n    <= '0;
      DATA <= 32'd0;
    end else begin
      if (take) begin
        bidx <= bidx + 2'd1;
        case (bidx)
          2'd0:    acc[7:0]   <= RX_DATA;
          2'd1:    acc[15:8]  <= RX_DATA;
          2'd2:    acc[23:16] <= RX_DATA;
          default: ;
        endcase
      end
      if (state == S_HDR && last)  n    <= word[IW-1:0];
      if (state == S_DATA && last) DATA <= word;
      if (state == S_WRITE && ACK) cnt  <= cnt_inc;
      if (restart) begin
        bidx <= 2'd0;
        cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_darkboot_loader.sv
// Bench for darkboot_loader: byte-queue reference model, per-cycle
// output compare, memory write log scoreboard and directed scenarios.
module tb_darkboot_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          MAXW = 512;

  logic        XCLK = 1'b0;
  logic        XRES = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VLD = 1'b0;
  logic        ACK = 1'b0;
  logic        START = 1'b0;
  logic        RX_RDY, WR, HOLD, DONE, ERR;
  logic [31:0] ADDR, DATA;
  logic [3:0]  BE;

  darkboot_loader #(.BASE(BASE), .MAXW(MAXW)) dut (
    .XCLK(XCLK), .XRES(XRES), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
    .RX_RDY(RX_RDY), .WR(WR), .ADDR(ADDR), .DATA(DATA), .BE(BE),
    .ACK(ACK), .START(START), .HOLD(HOLD), .DONE(DONE), .ERR(ERR)
  );

  always #5 XCLK = ~XCLK;

  int checks = 0;
  int fails  = 0;
  int ack_mode = 0;

  logic [7:0]  q[$];
  int          acked = 0;
  logic [63:0] dut_log[$];
  logic [63:0] mdl_log[$];
  logic [7:0]  tx_q[$];

  logic        wr_s = 1'b0;
  logic [31:0] addr_s, data_s;
  int          m_p, c_p;
  logic [8:0]  e_vec, g_vec;
  logic [31:0] e_addr, e_data;
  logic        ok;

  function automatic logic [31:0] m_hdr();
    if (q.size() < 4) return 32'd0;
    return {q[3], q[2], q[1], q[0]};
  endfunction

  function automatic logic [31:0] m_word(input int k);
    return {q[4*k+7], q[4*k+6], q[4*k+5], q[4*k+4]};
  endfunction

  // 0 receiving, 1 word waiting to be written, 2 finished, 3 rejected
  function automatic int m_phase();
    logic [31:0] h;
    h = m_hdr();
    if (q.size() < 4) return 0;
    if (h == 32'd0 || h == 32'(acked)) return 2;
    if (h > 32'(MAXW)) return 3;
    if (q.size() >= 4 * acked + 8) return 1;
    return 0;
  endfunction

  always @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      q.delete();
      acked = 0;
    end else begin
      m_p = m_phase();
      case (m_p)
        0: if (RX_VLD) q.push_back(RX_DATA);
        1: if (ACK) begin
          mdl_log.push_back({BASE + 32'(4 * acked), m_word(acked)});
          acked++;
        end
        default: if (START) begin
          q.delete();
          acked = 0;
        end
      endcase
    end
  end

  always @(negedge XCLK) begin
    wr_s   = WR;
    addr_s = ADDR;
    data_s = DATA;
    c_p    = m_phase();
    e_vec  = {!XRES && c_p == 0, c_p == 1, c_p != 2, c_p == 2, c_p == 3,
              (c_p == 1) ? 4'hF : 4'h0};
    g_vec  = {RX_RDY, WR, HOLD, DONE, ERR, BE};
    e_addr = BASE;
    e_data = 32'd0;
    ok     = (g_vec === e_vec);
    if (XRES) begin
      ok = ok && ADDR === BASE && DATA === 32'd0;
    end else if (c_p == 1) begin
      e_addr = BASE + 32'(4 * acked);
      e_data = m_word(acked);
      ok = ok && ADDR === e_addr && DATA === e_data;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL cycle_compare t=%0t rdy/wr/hold/done/err/be got %b exp %b addr got %h exp %h data got %h exp %h",
               $time, g_vec, e_vec, ADDR, e_addr, DATA, e_data);
    end
  end

  always @(posedge XCLK) begin
    if (wr_s && ACK && !XRES) dut_log.push_back({addr_s, data_s});
  end

  always @(posedge XCLK) begin
    #1;
    case (ack_mode)
      0:       ACK = wr_s && !ACK;
      1:       ACK = ($urandom % 3) == 0;
      2:       ACK = 1'b0;
      default: ACK = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [95:0] got,
                     input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge XCLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic send(input bit gap);
    logic rdy_s;
    int t;
    for (int k = 0; k < tx_q.size(); k++) begin
      RX_DATA = tx_q[k];
      RX_VLD  = 1'b1;
      t = 0;
      do begin
        @(negedge XCLK);
        rdy_s = RX_RDY;
        tick();
        t++;
      end while (!rdy_s && t < 300);
      if (!rdy_s) begin
        RX_VLD = 1'b0;
        checks++;
        fails++;
        $display("FAIL send_timeout: byte %0d not taken in %0d cycles, required <300", k, t);
        return;
      end
      if (gap) begin
        RX_VLD = 1'b0;
        tick();
      end
    end
    RX_VLD = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(DONE || ERR) && t < 1000) begin
      @(negedge XCLK);
      t++;
    end
    chk("finish_in_time", 96'(t < 1000), 96'd1);
    tick();
  endtask

  task automatic mk_image(input logic [31:0] n, input int words);
    tx_q.delete();
    for (int b = 0; b < 4; b++) tx_q.push_back(n[8*b +: 8]);
    for (int k = 0; k < 4 * words; k++) tx_q.push_back(8'($urandom));
  endtask

  function automatic logic [31:0] tx_word(input int k);
    return {tx_q[4*k+7], tx_q[4*k+6], tx_q[4*k+5], tx_q[4*k+4]};
  endfunction

  task automatic check_tail(input string name, input int words);
    int base_idx;
    base_idx = dut_log.size() - words;
    for (int k = 0; k < words; k++) begin
      chk(name, 96'(dut_log[base_idx + k]),
          96'({BASE + 32'(4 * k), tx_word(k)}));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sz;
    repeat (3) @(negedge XCLK);
    chk("reset_state", 96'({RX_RDY, WR, HOLD, DONE, ERR, BE, ADDR, DATA}),
        96'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, BASE, 32'h0}));
    @(posedge XCLK);
    #1 XRES = 1'b0;
    @(negedge XCLK);
    chk("rdy_after_reset", 96'(RX_RDY), 96'd1);
    tick();

    ack_mode = 0;
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66, 8'h77, 8'h88};
    send(1'b0);
    wait_end();
    chk("imgA_flags", 96'({DONE, HOLD, ERR}), 96'(3'b100));
    chk("imgA_count", 96'(dut_log.size()), 96'd2);
    chk("imgA_w0", 96'(dut_log[0]), 96'({BASE, 32'h4433_2211}));
    chk("imgA_w1", 96'(dut_log[1]), 96'({BASE + 32'd4, 32'h8877_6655}));
    chk("model_w1", 96'(mdl_log[1]), 96'({BASE + 32'd4, 32'h8877_6655}));

    pulse_start();
    ack_mode = 3;
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    send(1'b0);
    wait_end();
    repeat (5) tick();
    chk("zero_flags", 96'({DONE, ERR, HOLD}), 96'(3'b100));
    chk("zero_nowrite", 96'(dut_log.size()), 96'd2);

    pulse_start();
    ack_mode = 0;
    tx_q = '{8'h01, 8'h02, 8'h00, 8'h00};
    send(1'b0);
    wait_end();
    @(negedge XCLK);
    chk("over_err", 96'({ERR, HOLD, RX_RDY, DONE}), 96'(4'b1100));
    tick();
    pulse_start();
    @(negedge XCLK);
    chk("over_restart", 96'({ERR, DONE, HOLD, RX_RDY}), 96'(4'b0011));
    tick();

    ack_mode = 2;
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge XCLK);
      chk("stall_stable", 96'({WR, RX_RDY, ADDR, DATA, BE}),
          96'({1'b1, 1'b0, BASE, 32'hEFBE_ADDE, 4'hF}));
    end
    tick();
    ack_mode = 0;
    wait_end();
    chk("stall_count", 96'(dut_log.size()), 96'd3);

    pulse_start();
    ack_mode = 1;
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66, 8'h77, 8'h88};
    send(1'b1);
    wait_end();
    check_tail("gap_same", 2);

    pulse_start();
    ack_mode = 0;
    mk_image(32'd3, 2);
    send(1'b0);
    ack_mode = 2;
    @(negedge XCLK);
    chk("second_write", 96'({WR, ADDR}), 96'({1'b1, BASE + 32'd4}));
    @(posedge XCLK);
    #2 XRES = 1'b1;
    #1;
    chk("reset_drop", 96'({WR, HOLD, RX_RDY, ADDR}),
        96'({1'b0, 1'b1, 1'b0, BASE}));
    repeat (2) @(posedge XCLK);
    #1 XRES = 1'b0;
    ack_mode = 1;
    mk_image(32'd3, 3);
    send(1'b0);
    wait_end();
    chk("reload_done", 96'(DONE), 96'd1);
    check_tail("reload", 3);

    for (int r = 0; r < 6; r++) begin
      pulse_start();
      n = $urandom_range(1, 8);
      mk_image(32'(n), n);
      ack_mode = $urandom_range(0, 1);
      send(1'($urandom % 2));
      wait_end();
      chk("rand_done", 96'({DONE, ERR}), 96'(2'b10));
      check_tail("rand_mem", n);
    end

    pulse_start();
    mk_image(32'(MAXW + 1 + $urandom_range(0, 5000)), 0);
    send(1'b0);
    wait_end();
    chk("rand_over", 96'({DONE, ERR, HOLD}), 96'(3'b011));

    chk("log_size", 96'(dut_log.size()), 96'(mdl_log.size()));
    sz = (dut_log.size() < mdl_log.size()) ? dut_log.size() : mdl_log.size();
    for (int k = 0; k < sz; k++) begin
      chk("log_entry", 96'(dut_log[k]), 96'(mdl_log[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/darkboot_loader.md
DARKBOOT_LOADER -- requirements
Module: darkboot_loader

Interface
REQ-001 The block SHALL have parameter BASE, default 32'h0000_0000, which is the byte address of the first word written.
REQ-002 The block SHALL have parameter MAXW, default 512, which is the maximum image length in 32-bit words.
REQ-003 Clock and reset SHALL be one clock, XCLK, and reset XRES, which is asynchronous and active-high.
REQ-004 The ports SHALL be:
- XCLK  in  1  system clock
- XRES  in  1  async active-high reset
- RX_DATA  in  8  serial-side byte
- RX_VLD  in  1  byte valid
- RX_RDY  out  1  loader accepts byte
- WR  out  1  write request to memory responder
- ADDR  out  32  byte address, word aligned
- DATA  out  32  write data
- BE  out  4  byte enables
- ACK  in  1  responder accepted write
- START  in  1  single-cycle restart pulse
- HOLD  out  1  keeps core in reset while high
- DONE  out  1  image loaded
- ERR  out  1  header rejected

Function
REQ-005 A byte SHALL transfer only on a rising XCLK where RX_VLD=1 and RX_RDY=1.
REQ-006 Bytes SHALL assemble little-endian: the 1st byte goes to [7:0] and the 4th byte to [31:24].
REQ-007 The state machine SHALL have states HDR, DATA, WRITE, FIN and ERR.
REQ-008 In HDR, RX_RDY=1; the 4th accepted byte SHALL latch the full 32-bit word count N, then:
- N=0 -> FIN
- N>MAXW -> ERR
- otherwise -> DATA
REQ-009 In DATA, RX_RDY=1; the 4th accepted byte SHALL latch the word into DATA, and the next state SHALL be WRITE.
REQ-010 In WRITE, RX_RDY=0 and WR=1, ADDR=BASE+4*i (i = words already written, from 0), BE=4'hF; WR, ADDR, DATA and BE SHALL hold stable until ACK is sampled high.
REQ-011 On ACK in WRITE:
- WR deasserts the next cycle.
- i increments.
- If i reaches N, the next state SHALL be FIN; otherwise DATA.
REQ-012 ACK=1 while WR=0 SHALL be ignored, and ACK in the same cycle WR first rises SHALL complete the write (one-cycle minimum write).
REQ-013 ADDR arithmetic SHALL be 32-bit modulo 2^32, and i SHALL be $clog2(MAXW+1) bits wide.
REQ-014 In FIN, outputs SHALL be HOLD=0, DONE=1, RX_RDY=0 and WR=0, and incoming bytes SHALL be ignored.
REQ-015 In ERR, outputs SHALL be HOLD=1, ERR=1, RX_RDY=0 and WR=0.
REQ-016 START=1 in FIN or ERR SHALL, next cycle, enter HDR with the byte index cleared, i=0, HOLD=1, and DONE=ERR=0.
REQ-017 START SHALL be ignored in HDR, DATA and WRITE.
REQ-018 Throughput SHALL be bounded only by RX_VLD and ACK: back-to-back bytes are accepted every cycle in HDR and DATA.
REQ-019 DONE and ERR SHALL never be 1 simultaneously.
REQ-020 HOLD SHALL be 1 in every state except FIN.

Reset
REQ-021 While XRES=1, the following SHALL hold immediately and independent of XCLK:
- state = HDR
- byte index = 0, i = 0, N = 0
- ADDR = BASE, DATA = 0, BE = 0
- WR = 0, RX_RDY = 0
- HOLD = 1, DONE = 0, ERR = 0
REQ-022 In the first cycle after XRES falls, RX_RDY SHALL be 1.
REQ-023 XRES asserted mid-WRITE SHALL drop WR at once, abandon the partial image, and restart at HDR.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Header 02 00 00 00, then bytes 11 22 33 44 55 66 77 88, ACK after 1 cycle -> writes 0x44332211@BASE and 0x88776655@BASE+4; DONE=1, HOLD=0.
- Header 00 00 00 00 -> FIN directly; no WR pulse; DONE=1.
- Header 01 02 00 00 (N=513 > MAXW=512) -> ERR=1, HOLD=1, RX_RDY=0; then a START pulse -> HDR, ERR=0.
- ACK held low 5 cycles during a write -> WR/ADDR/DATA/BE stable for all 5 cycles and RX_RDY=0; a stray ACK while idle writes nothing.
- RX_VLD toggling 1/0 every cycle -> identical memory contents to the back-to-back case.
- XRES pulsed during the 2nd WRITE -> WR=0 immediately and HOLD=1; the next full image loads correctly from ADDR=BASE.
